// File: rtl/sequence_player_if.sv
// Control/status bundle between the game controller and sequence_player.
// The controller (master) drives writes, clear, start and the optional loop request.
// The player (slave) returns fill level, playback status and the cue symbol.
// Ports: wr_en, wr_sym, clear, start, [loop] -> player ; count, full, busy, out_sym, out_strobe, done <- player
// Optional: loop exists only when SEQUENCE_PLAYER_LOOP_EN is defined.
interface sequence_player_if #(
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 16
);
  localparam int SYM_W = $clog2(NUM_CH + 1);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             wr_en;
  logic [SYM_W-1:0] wr_sym;
  logic             clear;
  logic             start;
`ifdef SEQUENCE_PLAYER_LOOP_EN
  logic             loop;
`endif
  logic [CNT_W-1:0] count;
  logic             full;
  logic             busy;
  logic [SYM_W-1:0] out_sym;
  logic             out_strobe;
  logic             done;

  modport master (
`ifdef SEQUENCE_PLAYER_LOOP_EN
    output loop,
`endif
    output wr_en, wr_sym, clear, start,
    input  count, full, busy, out_sym, out_strobe, done
  );

  modport slave (
`ifdef SEQUENCE_PLAYER_LOOP_EN
    input  loop,
`endif
    input  wr_en, wr_sym, clear, start,
    output count, full, busy, out_sym, out_strobe, done
  );
endinterface

// File: rtl/sequence_player.sv
// Pattern store + timed playback of channel symbols for the station game (HOLD/GAP phases).
// Latency: start sampled at cycle t -> first cue symbol and strobe at t+1; all outputs registered.
// Backpressure: none; writes while busy/full or with an invalid symbol are silently dropped.
// Ports: clock_i, reset_i (sync, active-high); sp_if (slave modport of sequence_player_if).
// Optional: SEQUENCE_PLAYER_LOOP_EN adds sp_if.loop to repeat the sequence instead of finishing.
module sequence_player #(
  parameter int NUM_CH     = 4,
  parameter int DEPTH      = 16,
  parameter int TICK_DIV   = 4,
  parameter int HOLD_TICKS = 1,
  parameter int GAP_TICKS  = 1
) (
  input  logic             clock_i,
  input  logic             reset_i,
  sequence_player_if.slave sp_if
);
  localparam int SYM_W    = $clog2(NUM_CH + 1);
  localparam int CNT_W    = $clog2(DEPTH + 1);
  localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One cycle counter covers ticks*divider, so each phase is exactly its length.
  localparam int HOLD_LEN = HOLD_TICKS * TICK_DIV;
  localparam int GAP_LEN  = GAP_TICKS * TICK_DIV;
  localparam int MAX_LEN  = (HOLD_LEN > GAP_LEN) ? HOLD_LEN : GAP_LEN;
  localparam int PH_W     = $clog2(MAX_LEN + 1);
  localparam logic [PH_W-1:0] HOLD_LAST = PH_W'(HOLD_LEN - 1);
  localparam logic [PH_W-1:0] GAP_LAST  = PH_W'(GAP_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_GAP, S_DONE} state_e;

  state_e           state_q;
  logic [SYM_W-1:0] buf_q [DEPTH];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] idx_q;
  logic [PH_W-1:0]  phase_q;
  logic             busy_q;
  logic [SYM_W-1:0] sym_q;
  logic             strobe_q;
  logic             done_q;

  logic             full_d;
  logic             wr_ok_d;
  logic [CNT_W-1:0] idx_nxt_d;
  logic             more_d;
  logic [PH_W-1:0]  phase_nxt_d;
  logic             loop_d;

  assign full_d      = (count_q == CNT_W'(DEPTH));
  assign wr_ok_d     = sp_if.wr_en && !full_d && (sp_if.wr_sym != '0) &&
                       (sp_if.wr_sym <= SYM_W'(NUM_CH));
  // idx_q <= count-1 <= DEPTH-1, so idx_q+1 always fits in CNT_W bits.
  assign idx_nxt_d   = idx_q + CNT_W'(1);
  assign more_d      = (idx_nxt_d < count_q);
  assign phase_nxt_d = phase_q + PH_W'(1);
`ifdef SEQUENCE_PLAYER_LOOP_EN
  assign loop_d      = sp_if.loop;
`else
  assign loop_d      = 1'b0;
`endif

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      idx_q    <= '0;
      phase_q  <= '0;
      busy_q   <= 1'b0;
      sym_q    <= '0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (sp_if.clear) begin
            count_q <= '0;
          end else if (sp_if.start) begin
            if (count_q == '0) begin
              done_q <= 1'b1;  // nothing to play: report completion immediately
            end else begin
              state_q  <= S_HOLD;
              busy_q   <= 1'b1;
              idx_q    <= '0;
              phase_q  <= '0;
              sym_q    <= buf_q[0];
              strobe_q <= 1'b1;
            end
          end else if (wr_ok_d) begin
            buf_q[count_q[AW-1:0]] <= sp_if.wr_sym;
            count_q                <= count_q + CNT_W'(1);
          end
        end
        S_HOLD, S_GAP: begin
          if (sp_if.clear) begin
            // Abort: drop the stored sequence, no done pulse.
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            sym_q   <= '0;
            count_q <= '0;
            phase_q <= '0;
          end else if (state_q == S_HOLD) begin
            if (phase_q == HOLD_LAST) begin
              state_q <= S_GAP;
              phase_q <= '0;
              sym_q   <= '0;
            end else begin
              phase_q <= phase_nxt_d;
            end
          end else if (phase_q == GAP_LAST) begin
            phase_q <= '0;
            if (more_d) begin
              state_q  <= S_HOLD;
              idx_q    <= idx_nxt_d;
              sym_q    <= buf_q[idx_nxt_d[AW-1:0]];
              strobe_q <= 1'b1;
            end else if (loop_d) begin
              state_q  <= S_HOLD;
              idx_q    <= '0;
              sym_q    <= buf_q[0];
              strobe_q <= 1'b1;
            end else begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            phase_q <= phase_nxt_d;
          end
        end
        S_DONE: begin
          // One-cycle completion state; buffer kept for replay.
          state_q <= S_IDLE;
          if (sp_if.clear) count_q <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sp_if.count      = count_q;
  assign sp_if.full       = full_d;
  assign sp_if.busy       = busy_q;
  assign sp_if.out_sym    = sym_q;
  assign sp_if.out_strobe = strobe_q;
  assign sp_if.done       = done_q;
endmodule

// File: tb/tb_sequence_player.sv
// Bench for sequence_player: per-cycle vector table with a scoreboard queue of expected outputs,
// plus a hand-written full-length playback with a bounded wait for done.
// Config: NUM_CH=4, DEPTH=4, TICK_DIV=2, HOLD_TICKS=1, GAP_TICKS=1.
module tb_sequence_player;
  localparam int NUM_CH     = 4;
  localparam int DEPTH      = 4;
  localparam int TICK_DIV   = 2;
  localparam int HOLD_TICKS = 1;
  localparam int GAP_TICKS  = 1;
  localparam int SYM_W      = $clog2(NUM_CH + 1);
  localparam int CNT_W      = $clog2(DEPTH + 1);

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sequence_player_if #(.NUM_CH(NUM_CH), .DEPTH(DEPTH)) sp_if ();

  sequence_player #(
    .NUM_CH(NUM_CH), .DEPTH(DEPTH), .TICK_DIV(TICK_DIV),
    .HOLD_TICKS(HOLD_TICKS), .GAP_TICKS(GAP_TICKS)
  ) dut (
    .clock_i(clock),
    .reset_i(reset),
    .sp_if  (sp_if)
  );

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic             full;
    logic             busy;
    logic [SYM_W-1:0] sym;
    logic             strb;
    logic             done;
  } out_t;

  typedef struct {
    logic             rst;
    logic             wr;
    logic [SYM_W-1:0] sym;
    logic             clr;
    logic             st;
    logic             lp;
    out_t             exp;
  } vec_t;

  vec_t vecs[$];
  out_t exp_q[$];
  int   sym_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic void add(int rst, int wr, int sym, int clr, int st, int lp,
                              int cnt, int full, int busy, int osym, int strb, int done);
    vec_t v;
    v.rst      = 1'(rst);
    v.wr       = 1'(wr);
    v.sym      = SYM_W'(sym);
    v.clr      = 1'(clr);
    v.st       = 1'(st);
    v.lp       = 1'(lp);
    v.exp.cnt  = CNT_W'(cnt);
    v.exp.full = 1'(full);
    v.exp.busy = 1'(busy);
    v.exp.sym  = SYM_W'(osym);
    v.exp.strb = 1'(strb);
    v.exp.done = 1'(done);
    vecs.push_back(v);
  endfunction

  function automatic out_t sample();
    out_t o;
    o.cnt  = sp_if.count;
    o.full = sp_if.full;
    o.busy = sp_if.busy;
    o.sym  = sp_if.out_sym;
    o.strb = sp_if.out_strobe;
    o.done = sp_if.done;
    return o;
  endfunction

  task automatic chk_out(input string name, input out_t got, input out_t exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got cnt=%0d full=%0d busy=%0d sym=%0d strb=%0d done=%0d, want cnt=%0d full=%0d busy=%0d sym=%0d strb=%0d done=%0d",
               name, got.cnt, got.full, got.busy, got.sym, got.strb, got.done,
               exp.cnt, exp.full, exp.busy, exp.sym, exp.strb, exp.done);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, got, exp);
    end
  endtask

  task automatic drive(input logic wr, input int sym, input logic clr, input logic st);
    sp_if.wr_en  = wr;
    sp_if.wr_sym = SYM_W'(sym);
    sp_if.clear  = clr;
    sp_if.start  = st;
  endtask

  initial begin
    int   done_cyc;
    bit   seen_done;
    out_t got;

    drive(1'b0, 0, 1'b0, 1'b0);
`ifdef SEQUENCE_PLAYER_LOOP_EN
    sp_if.loop = 1'b0;
`endif

    //   rst wr sym clr st lp | cnt full busy osym strb done
    add(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);  // reset values
    // two-symbol playback, start at "cycle 0"
    add(0, 1, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0);
    add(0, 1, 3, 0, 0, 0,   2, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0,   2, 0, 1, 1, 1, 0);  // cyc 1
    add(0, 0, 0, 0, 0, 0,   2, 0, 1, 1, 0, 0);  // cyc 2
    add(0, 0, 0, 0, 0, 0,   2, 0, 1, 0, 0, 0);  // cyc 3
    add(0, 0, 0, 0, 0, 0,   2, 0, 1, 0, 0, 0);  // cyc 4
    add(0, 0, 0, 0, 0, 0,   2, 0, 1, 3, 1, 0);  // cyc 5
    add(0, 0, 0, 0, 0, 0,   2, 0, 1, 3, 0, 0);  // cyc 6
    add(0, 0, 0, 0, 0, 0,   2, 0, 1, 0, 0, 0);  // cyc 7
    add(0, 0, 0, 0, 0, 0,   2, 0, 1, 0, 0, 0);  // cyc 8
    add(0, 0, 0, 0, 0, 0,   2, 0, 0, 0, 0, 1);  // cyc 9 done
    add(0, 0, 0, 0, 0, 0,   2, 0, 0, 0, 0, 0);
    // fill to full, overflow and invalid symbols dropped
    add(0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0);
    add(0, 1, 2, 0, 0, 0,   1, 0, 0, 0, 0, 0);
    add(0, 1, 4, 0, 0, 0,   2, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0,   3, 0, 0, 0, 0, 0);
    add(0, 1, 3, 0, 0, 0,   4, 1, 0, 0, 0, 0);
    add(0, 1, 2, 0, 0, 0,   4, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    add(0, 1, 5, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    add(0, 1, 7, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    // start on empty buffer
    add(0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    // start beats write; writes and start while busy ignored
    add(0, 1, 4, 0, 0, 0,   1, 0, 0, 0, 0, 0);
    add(0, 1, 2, 0, 1, 0,   1, 0, 1, 4, 1, 0);
    add(0, 1, 1, 0, 0, 0,   1, 0, 1, 4, 0, 0);
    add(0, 1, 1, 0, 0, 0,   1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0,   1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
    // replay of retained buffer
    add(0, 0, 0, 0, 1, 0,   1, 0, 1, 4, 1, 0);
    add(0, 0, 0, 0, 0, 0,   1, 0, 1, 4, 0, 0);
    add(0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
    // clear mid-playback (during cycle 4)
    add(0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0);
    add(0, 1, 2, 0, 0, 0,   2, 0, 0, 0, 0, 0);
    add(0, 1, 3, 0, 0, 0,   3, 0, 0, 0, 0, 0);
    add(0, 1, 4, 0, 0, 0,   4, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0,   4, 1, 1, 1, 1, 0);  // cyc 1
    add(0, 0, 0, 0, 0, 0,   4, 1, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,   4, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   4, 1, 1, 0, 0, 0);  // cyc 4
    add(0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0);  // cyc 5 aborted
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);  // no done
    // reset mid-playback
    add(0, 1, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0);
    add(0, 1, 2, 0, 0, 0,   2, 0, 0, 0, 0, 0);
    add(0, 1, 3, 0, 0, 0,   3, 0, 0, 0, 0, 0);
    add(0, 1, 4, 0, 0, 0,   4, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0,   4, 1, 1, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0,   4, 1, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,   4, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   4, 1, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    // clear beats start and write
    add(0, 1, 3, 0, 0, 0,   1, 0, 0, 0, 0, 0);
    add(0, 1, 2, 1, 1, 0,   0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
`ifdef SEQUENCE_PLAYER_LOOP_EN
    // looping single symbol, then loop dropped -> done after current GAP
    add(0, 1, 2, 0, 0, 0,   1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1,   1, 0, 1, 2, 1, 0);
    add(0, 0, 0, 0, 0, 1,   1, 0, 1, 2, 0, 0);
    add(0, 0, 0, 0, 0, 1,   1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1,   1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1,   1, 0, 1, 2, 1, 0);
    add(0, 0, 0, 0, 0, 1,   1, 0, 1, 2, 0, 0);
    add(0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      reset = vecs[i].rst;
      drive(vecs[i].wr, int'(vecs[i].sym), vecs[i].clr, vecs[i].st);
`ifdef SEQUENCE_PLAYER_LOOP_EN
      sp_if.loop = vecs[i].lp;
`endif
      exp_q.push_back(vecs[i].exp);
      @(posedge clock);
      #1;
      got = sample();
      chk_out($sformatf("vec%0d", i), got, exp_q.pop_front());
    end

    // Full four-symbol playback: strobed symbols scored against writes, done at cycle 17.
    @(negedge clock);
    reset = 1'b0;
`ifdef SEQUENCE_PLAYER_LOOP_EN
    sp_if.loop = 1'b0;
`endif
    drive(1'b0, 0, 1'b1, 1'b0);
    for (int s = 1; s <= 4; s++) begin
      @(negedge clock);
      drive(1'b1, s, 1'b0, 1'b0);
      sym_q.push_back(s);
    end
    @(negedge clock);
    drive(1'b0, 0, 1'b0, 1'b0);
    chk_int("count_after_fill", int'(sp_if.count), 4);
    drive(1'b0, 0, 1'b0, 1'b1);
    seen_done = 1'b0;
    done_cyc  = 0;
    for (int c = 1; c <= 60 && !seen_done; c++) begin
      @(posedge clock);
      #1;
      sp_if.start = 1'b0;
      if (sp_if.out_strobe) begin
        if (sym_q.size() == 0) chk_int("extra_strobe_sym", int'(sp_if.out_sym), 0);
        else chk_int($sformatf("strobe_sym_c%0d", c), int'(sp_if.out_sym), sym_q.pop_front());
      end
      if (sp_if.done) begin
        seen_done = 1'b1;
        done_cyc  = c;
      end
    end
    chk_int("done_seen", int'(seen_done), 1);
    chk_int("done_cycle", done_cyc, 17);
    chk_int("missing_strobes", sym_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
